pv_check_seq: RTL and testbench

- Parametrised successor to the point-verification top for binary-field ECC over GF(2^N), generic polynomial basis.
- Two modes:
  - Mode 0: projective x-coordinate equality, X1/Z1 == X2/Z2.
  - Mode 1: affine on-curve check, y^2 + x*y == x^3 + a*x^2 + b.
- Self-contained: one internal digit-serial multiplier, combinational squarer/adders, and a sequencing FSM.
- Sits between the scalar-multiplication core and the host result interface.

---
 rtl/pv_check_seq_if.sv | 32 +++
 rtl/pv_check_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_pv_check_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pv_check_seq_if.sv
// Request/result bundle for pv_check_seq.
// Macro: none; both builds of pv_check_seq use the same interface.
//   master: host side. It drives the request, the operands and the curve coefficients,
//           and receives IN_READY and the result.
//   slave : checker side, the mirror image of master.
// Signal names match the checker's published port list.
interface pv_check_seq_if #(
  parameter int unsigned N = 233
);
  logic         IN_VALID;
  logic         IN_READY;
  logic         MODE;
  logic [N-1:0] DIN_P1_X;
  logic [N-1:0] DIN_P1_Z;
  logic [N-1:0] DIN_P2_X;
  logic [N-1:0] DIN_P2_Z;
  logic [N-1:0] CURVE_A;
  logic [N-1:0] CURVE_B;
  logic         OUT_VALID;
  logic         SUCCESS;
  logic         FAULT;

  modport master (
    output IN_VALID, MODE, DIN_P1_X, DIN_P1_Z, DIN_P2_X, DIN_P2_Z, CURVE_A, CURVE_B,
    input  IN_READY, OUT_VALID, SUCCESS, FAULT
  );

  modport slave (
    input  IN_VALID, MODE, DIN_P1_X, DIN_P1_Z, DIN_P2_X, DIN_P2_Z, CURVE_A, CURVE_B,
    output IN_READY, OUT_VALID, SUCCESS, FAULT
  );
endinterface

// File: rtl/pv_check_seq.sv
// Point verification for binary-field ECC over GF(2^N) in polynomial basis.
//   MODE 0: projective x equality, X1*Z2 == X2*Z1. Z = 0 is handled as the point at infinity.
//   MODE 1: affine on-curve test, y^2 + x*y == x^3 + a*x^2 + b.
// The checker has one MSB-first digit-serial multiplier. It takes K = ceil(N/D) cycles per
// product. The squarer and the adders are combinational.
// Ports:
//   CLK : rising-edge clock.
//   RST : synchronous reset, active high. It discards any request that is in flight.
//   bus : pv_check_seq_if slave. It carries the request, the operands, and the
//         OUT_VALID / SUCCESS / FAULT result pulse.
// Sequence: IDLE -> LOAD -> MUL1 -> MUL2 [-> MUL3] -> CMP -> DONE -> IDLE.
// Optional feature: macro PV_DUP_MUL_EN.
//   When it is defined, a second multiplier computes B*A in lockstep with the main one.
//   Any disagreement sets a sticky FAULT, and FAULT forces SUCCESS to 0.
//   When it is not defined, FAULT is always 0.
module pv_check_seq #(
  parameter int unsigned  N    = 233,
  parameter logic [N-1:0] POLY = 233'h400_0000_0000_0000_0001,
  parameter int unsigned  D    = 4
) (
  input logic           CLK,
  input logic           RST,
  pv_check_seq_if.slave bus
);

  localparam int unsigned K    = (N + D - 1) / D;
  localparam int unsigned PadW = K * D;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul1,
    StMul2,
    StMul3,
    StCmp,
    StDone
  } state_e;

  // Multiply by x, then reduce mod x^N + POLY.
  function automatic logic [N-1:0] xtime(input logic [N-1:0] v);
    return {v[N-2:0], 1'b0} ^ (v[N-1] ? POLY : '0);
  endfunction

  // One multiplier cycle: acc * x^D + a * dig. Horner form keeps every step reduced.
  function automatic logic [N-1:0] mul_step(input logic [N-1:0] acc, input logic [N-1:0] a,
                                            input logic [D-1:0] dig);
    logic [N-1:0] t;
    t = acc;
    for (int i = D - 1; i >= 0; i--) begin
      t = xtime(t) ^ (dig[i] ? a : '0);
    end
    return t;
  endfunction

  // Spread the bits, then fold the high part back in from the top down.
  function automatic logic [N-1:0] gf_sqr(input logic [N-1:0] v);
    logic [2*N-2:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w[2*i] = v[i];
    end
    for (int j = 2 * N - 2; j >= N; j--) begin
      if (w[j]) begin
        w[j]         = 1'b0;
        w[j-N +: N] = w[j-N +: N] ^ POLY;
      end
    end
    return w[N-1:0];
  endfunction

  // Pick the digit of b used in count position cnt, most significant digit first.
  function automatic logic [D-1:0] digit_of(input logic [N-1:0] b, input logic [CntW-1:0] cnt);
    logic [PadW-1:0] pad;
    pad = PadW'(b) >> ((K - 1 - int'(cnt)) * D);
    return pad[D-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            mode_q, mode_d;
  logic [N-1:0]    x1_q, x1_d, z1_q, z1_d, x2_q, x2_d, z2_q, z2_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    t_q, t_d, s_q, s_d;
  logic [N-1:0]    m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic            success_q, success_d;

  logic [N-1:0]    op_a, op_b, step;
  logic [D-1:0]    dig;
  logic            last, need_mul3, fault_out;
  logic            z1_zero, z2_zero;
  logic [N-1:0]    a_term, lhs, rhs;

`ifdef PV_DUP_MUL_EN
  logic [N-1:0]    dup_acc_q, dup_acc_d, dup_step;
  logic            fault_q, fault_d;
`endif

  // Operand routing. In both modes MUL1 reads the same two registers (X1/x and Z2/y).
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      StMul1: begin
        op_a = x1_q;
        op_b = z2_q;
      end
      StMul2: begin
        op_a = mode_q ? t_q : x2_q;
        op_b = mode_q ? x1_q : z1_q;
      end
      StMul3: begin
        op_a = a_q;
        op_b = t_q;
      end
      default: ;
    endcase
  end

  assign dig       = digit_of(op_b, cnt_q);
  assign step      = mul_step(acc_q, op_a, dig);
  assign last      = (cnt_q == CntW'(K - 1));
  assign need_mul3 = mode_q && (a_q != '0) && (a_q != N'(1));

`ifdef PV_DUP_MUL_EN
  // Swapped operands: the product should agree with the main multiplier bit for bit.
  assign dup_step = mul_step(dup_acc_q, op_b, digit_of(op_a, cnt_q));
`endif

  // Result comparison terms. They are registered in CMP.
  assign z1_zero = (z1_q == '0);
  assign z2_zero = (z2_q == '0);
  assign a_term  = (a_q == '0) ? '0 : (a_q == N'(1)) ? t_q : m3_q;
  assign lhs     = s_q ^ m1_q;
  assign rhs     = m2_q ^ a_term ^ b_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    x1_d      = x1_q;
    z1_d      = z1_q;
    x2_d      = x2_q;
    z2_d      = z2_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    s_d       = s_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    m3_d      = m3_q;
    success_d = success_q;
`ifdef PV_DUP_MUL_EN
    dup_acc_d = dup_acc_q;
    fault_d   = fault_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.IN_VALID) begin
          mode_d    = bus.MODE;
          x1_d      = bus.DIN_P1_X;
          z1_d      = bus.DIN_P1_Z;
          x2_d      = bus.DIN_P2_X;
          z2_d      = bus.DIN_P2_Z;
          a_d       = bus.CURVE_A;
          b_d       = bus.CURVE_B;
          success_d = 1'b0;
`ifdef PV_DUP_MUL_EN
          fault_d   = 1'b0;
`endif
          state_d   = StLoad;
        end
      end
      StLoad: begin
        t_d     = gf_sqr(x1_q);
        s_d     = gf_sqr(z2_q);
        acc_d   = '0;
        cnt_d   = '0;
`ifdef PV_DUP_MUL_EN
        dup_acc_d = '0;
`endif
        state_d = StMul1;
      end
      StMul1, StMul2, StMul3: begin
        acc_d = step;
        cnt_d = cnt_q + CntW'(1);
`ifdef PV_DUP_MUL_EN
        dup_acc_d = dup_step;
`endif
        if (last) begin
          // Clear the accumulator here, so the next product starts from zero.
          acc_d = '0;
          cnt_d = '0;
`ifdef PV_DUP_MUL_EN
          dup_acc_d = '0;
          if (dup_step != step) begin
            fault_d = 1'b1;
          end
`endif
          if (state_q == StMul1) begin
            m1_d    = step;
            state_d = StMul2;
          end else if (state_q == StMul2) begin
            m2_d    = step;
            state_d = need_mul3 ? StMul3 : StCmp;
          end else begin
            m3_d    = step;
            state_d = StCmp;
          end
        end
      end
      StCmp: begin
        if (!mode_q) begin
          // Two zero Zs means both points are at infinity. A single zero Z always mismatches.
          if (z1_zero && z2_zero) begin
            success_d = 1'b1;
          end else if (z1_zero || z2_zero) begin
            success_d = 1'b0;
          end else begin
            success_d = (m1_q == m2_q);
          end
        end else begin
          success_d = (lhs == rhs);
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      success_q <= success_d;
    end
  end

  // The datapath registers are always written before they are read, so they have no reset.
  always_ff @(posedge CLK) begin
    mode_q <= mode_d;
    x1_q   <= x1_d;
    z1_q   <= z1_d;
    x2_q   <= x2_d;
    z2_q   <= z2_d;
    a_q    <= a_d;
    b_q    <= b_d;
    t_q    <= t_d;
    s_q    <= s_d;
    m1_q   <= m1_d;
    m2_q   <= m2_d;
    m3_q   <= m3_d;
  end

`ifdef PV_DUP_MUL_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      dup_acc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      dup_acc_q <= dup_acc_d;
      fault_q   <= fault_d;
    end
  end

  assign fault_out = fault_q;
`else
  assign fault_out = 1'b0;
`endif

  assign bus.IN_READY  = (state_q == StIdle);
  assign bus.OUT_VALID = (state_q == StDone);
  assign bus.SUCCESS   = bus.OUT_VALID & success_q & ~fault_out;
  assign bus.FAULT     = bus.OUT_VALID & fault_out;

endmodule

// File: tb/tb_pv_check_seq.sv
// Directed bench for pv_check_seq in GF(2^4) with x^4 = x + 1 (POLY = 4'b0011).
// dut uses D = 1 (K = 4). dut3 uses D = 3 (K = 2).
// Each table entry is applied to one of the two instances. The bench checks SUCCESS, the latency
// (cycles from the accept edge to OUT_VALID), FAULT, and that OUT_VALID lasts a single cycle.
// Hand-written sequences cover a busy request, a mid-operation reset and the PV_DUP_MUL_EN fault.
module tb_pv_check_seq;
  localparam int unsigned N = 4;
  localparam logic [N-1:0] POLY = 4'b0011;

  typedef struct {
    bit         sel;       // 0: dut (D=1), 1: dut3 (D=3)
    bit         mode;
    logic [3:0] x1, z1, x2, z2, a, b;
    bit         exp_succ;
    int         exp_lat;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  pv_check_seq_if #(.N(N)) bus1 ();
  pv_check_seq_if #(.N(N)) bus3 ();

  pv_check_seq #(.N(N), .POLY(POLY), .D(1)) dut  (.CLK(CLK), .RST(RST), .bus(bus1));
  pv_check_seq #(.N(N), .POLY(POLY), .D(3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.sel) begin
      bus3.IN_VALID = 1'b1; bus3.MODE = v.mode;
      bus3.DIN_P1_X = v.x1; bus3.DIN_P1_Z = v.z1; bus3.DIN_P2_X = v.x2; bus3.DIN_P2_Z = v.z2;
      bus3.CURVE_A = v.a; bus3.CURVE_B = v.b;
    end else begin
      bus1.IN_VALID = 1'b1; bus1.MODE = v.mode;
      bus1.DIN_P1_X = v.x1; bus1.DIN_P1_Z = v.z1; bus1.DIN_P2_X = v.x2; bus1.DIN_P2_Z = v.z2;
      bus1.CURVE_A = v.a; bus1.CURVE_B = v.b;
    end
  endtask

  // Drop the request and scramble the operands. The DUT must already have registered them.
  task automatic clear_in(input bit sel);
    if (sel) begin
      bus3.IN_VALID = 1'b0; bus3.MODE = 1'($urandom);
      bus3.DIN_P1_X = 4'($urandom); bus3.DIN_P1_Z = 4'($urandom);
      bus3.DIN_P2_X = 4'($urandom); bus3.DIN_P2_Z = 4'($urandom);
      bus3.CURVE_A = 4'($urandom); bus3.CURVE_B = 4'($urandom);
    end else begin
      bus1.IN_VALID = 1'b0; bus1.MODE = 1'($urandom);
      bus1.DIN_P1_X = 4'($urandom); bus1.DIN_P1_Z = 4'($urandom);
      bus1.DIN_P2_X = 4'($urandom); bus1.DIN_P2_Z = 4'($urandom);
      bus1.CURVE_A = 4'($urandom); bus1.CURVE_B = 4'($urandom);
    end
  endtask

  function automatic bit out_valid(input bit sel);
    return sel ? bus3.OUT_VALID : bus1.OUT_VALID;
  endfunction

  // Call this at #1 after an edge, with the DUT idle. The task returns at #1 after the cycle
  // that follows DONE, or with lat = 0 if no OUT_VALID arrives within 40 cycles.
  task automatic run_req(input vec_t v, output bit succ, output bit flt, output int lat);
    drive(v);
    @(posedge CLK); #1;
    clear_in(v.sel);
    lat  = 0;
    succ = 1'b0;
    flt  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid(v.sel)) begin
        lat  = c;
        succ = v.sel ? bus3.SUCCESS : bus1.SUCCESS;
        flt  = v.sel ? bus3.FAULT : bus1.FAULT;
        break;
      end
      @(posedge CLK); #1;
    end
    if (lat != 0) begin
      @(posedge CLK); #1;
    end
  endtask

  vec_t vecs[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected it to finish on its own");
    $fatal(1);
  end

  initial begin
    bit succ, flt;
    int lat, pulses, first_lat;
    bit first_succ;

    //          sel mode x1  z1  x2  z2  a   b   succ lat
    vecs[0]  = '{0, 0, 3,  1,  6,  2,  0,  0,  1, 11};
    vecs[1]  = '{0, 0, 3,  1,  6,  3,  0,  0,  0, 11};
    vecs[2]  = '{0, 0, 5,  0,  9,  0,  0,  0,  1, 11};
    vecs[3]  = '{0, 0, 5,  0,  9,  1,  0,  0,  0, 11};
    vecs[4]  = '{0, 0, 0,  0,  5,  3,  0,  0,  0, 11};  // products equal, only Z1 is zero
    vecs[5]  = '{0, 1, 1, 10, 11,  2,  0,  7,  1, 11};
    vecs[6]  = '{0, 1, 1, 10, 11,  3,  0,  7,  1, 11};
    vecs[7]  = '{0, 1, 1, 10, 11,  4,  0,  7,  0, 11};
    vecs[8]  = '{0, 1, 2, 10, 11,  1,  1, 15,  1, 11};  // a = 1 uses T, no MUL3
    vecs[9]  = '{0, 1, 2, 10, 11,  1,  2,  3,  1, 15};  // general a adds MUL3
    vecs[10] = '{0, 1, 2, 10, 11,  5,  2,  3,  0, 15};
    vecs[11] = '{1, 0, 3,  1,  6,  2,  0,  0,  1,  7};
    vecs[12] = '{1, 0, 3,  1,  6,  3,  0,  0,  0,  7};
    vecs[13] = '{1, 0, 5,  0,  9,  0,  0,  0,  1,  7};
    vecs[14] = '{1, 0, 5,  0,  9,  1,  0,  0,  0,  7};
    vecs[15] = '{1, 0, 0,  0,  5,  3,  0,  0,  0,  7};
    vecs[16] = '{1, 1, 1, 10, 11,  2,  0,  7,  1,  7};
    vecs[17] = '{1, 1, 2, 10, 11,  1,  2,  3,  1,  9};
    vecs[18] = '{1, 1, 2, 10, 11,  3,  2,  3,  1,  9};
    vecs[19] = '{1, 1, 2, 10, 11,  5,  2,  3,  0,  9};

    clear_in(1'b0);
    clear_in(1'b1);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset IN_READY", bus1.IN_READY, 1);
    check("reset OUT_VALID", bus1.OUT_VALID, 0);
    check("reset SUCCESS", bus1.SUCCESS, 0);
    check("reset FAULT", bus1.FAULT, 0);
    check("reset dut3 IN_READY", bus3.IN_READY, 1);

    for (int i = 0; i < 20; i++) begin
      run_req(vecs[i], succ, flt, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d SUCCESS", i), succ, vecs[i].exp_succ);
      check($sformatf("vec%0d FAULT", i), flt, 0);
      check($sformatf("vec%0d OUT_VALID one cycle", i), out_valid(vecs[i].sel), 0);
    end

    // Busy: a second request raised during MUL1 must be dropped.
    drive(vecs[0]);
    @(posedge CLK); #1;
    clear_in(1'b0);
    pulses = 0; first_lat = 0; first_succ = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) begin
        check("busy IN_READY", bus1.IN_READY, 0);
        drive(vecs[1]);
      end
      if (c == 4) clear_in(1'b0);
      if (bus1.OUT_VALID) begin
        pulses++;
        if (pulses == 1) begin
          first_lat  = c;
          first_succ = bus1.SUCCESS;
        end
      end
      @(posedge CLK); #1;
    end
    check("busy pulse count", pulses, 1);
    check("busy latency", first_lat, 11);
    check("busy SUCCESS", first_succ, 1);

    // Reset during MUL2 (cycle 6 of a K=4 request).
    drive(vecs[0]);
    @(posedge CLK); #1;
    clear_in(1'b0);
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) RST = 1'b1;
      if (c == 7) begin
        RST = 1'b0;
        check("post-reset IN_READY", bus1.IN_READY, 1);
      end
      if (bus1.OUT_VALID) pulses++;
      @(posedge CLK); #1;
    end
    check("reset drops result", pulses, 0);
    run_req(vecs[0], succ, flt, lat);
    check("after reset latency", lat, 11);
    check("after reset SUCCESS", succ, 1);

`ifdef PV_DUP_MUL_EN
    // Flip bit 0 of the duplicate accumulator in the middle of MUL1.
    drive(vecs[0]);
    @(posedge CLK); #1;
    clear_in(1'b0);
    lat = 0; succ = 1'b0; flt = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin
        logic [N-1:0] flip;
        @(negedge CLK);
        flip = dut.dup_acc_q ^ 4'h1;
        force dut.dup_acc_q = flip;
        #1;
        release dut.dup_acc_q;
        @(posedge CLK); #1;
        continue;
      end
      if (bus1.OUT_VALID) begin
        lat = c; succ = bus1.SUCCESS; flt = bus1.FAULT;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    check("dup fault latency", lat, 11);
    check("dup fault FAULT", flt, 1);
    check("dup fault SUCCESS", succ, 0);
    run_req(vecs[0], succ, flt, lat);
    check("dup clean FAULT", flt, 0);
    check("dup clean SUCCESS", succ, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
